// File: rtl/div_unit_pkg.sv
// div_unit_pkg: shared encodings for the multi-cycle divider and the EX stage.
// Holds FSM state encodings, ready/start levels, and the DIV/DIVU aluop codes.
package div_unit_pkg;

  localparam int DivDataW = 32;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } divState_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

  localparam logic [7:0] AluopDiv  = 8'b0001_1010;
  localparam logic [7:0] AluopDivu = 8'b0001_1011;

  // Lets EX decide whether an aluop needs the divider and the pipeline stall.
  function automatic logic isDivAluop(input logic [7:0] aluop);
    return (aluop == AluopDiv) || (aluop == AluopDivu);
  endfunction

endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division step.
// Shifts {rem,dvd} left by one, trial-subtracts the divisor and keeps the
// difference when it is non-negative; the new quotient bit enters dvd's LSB.
module div_step
  import div_unit_pkg::*;
#(
  parameter int DATA_W = DivDataW
) (
  input  logic [DATA_W-1:0] i_rem,
  input  logic [DATA_W-1:0] i_dvd,
  input  logic [DATA_W-1:0] i_divisor,
  output logic [DATA_W-1:0] o_rem,
  output logic [DATA_W-1:0] o_dvd,
  output logic              o_qbit
);

  logic [DATA_W:0] w_shifted;
  logic [DATA_W:0] w_trial;

  // Trial subtract is one bit wider so its MSB acts as the borrow/sign flag.
  always_comb begin
    w_shifted = {i_rem, i_dvd[DATA_W-1]};
    w_trial   = w_shifted - {1'b0, i_divisor};
    o_qbit    = ~w_trial[DATA_W];
    o_rem     = o_qbit ? w_trial[DATA_W-1:0] : w_shifted[DATA_W-1:0];
    o_dvd     = {i_dvd[DATA_W-2:0], o_qbit};
  end

endmodule

// File: rtl/div_unit.sv
// div_unit: radix-2 multi-cycle integer divider for DIV/DIVU.
// Returns {remainder, quotient} with a registered ready flag, one quotient
// bit per cycle. Optional build macro DIV_FAST_ZERO_DIVIDEND_EN makes a zero
// dividend take the short divide-by-zero path instead of the full iteration.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int DATA_W = DivDataW
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                start_i,
  input  logic                annul_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o
);

  localparam int              CntW     = $clog2(DATA_W);
  localparam logic [CntW-1:0] LastStep = CntW'(DATA_W - 1);

  divState_e         r_state;
  logic [CntW-1:0]   r_cnt;
  logic [DATA_W-1:0] r_rem;
  logic [DATA_W-1:0] r_dvd;
  logic [DATA_W-1:0] r_divisor;
  logic              r_sign1;
  logic              r_sign2;

  divState_e           w_stateNext;
  logic [CntW-1:0]     w_cntNext;
  logic [DATA_W-1:0]   w_remNext;
  logic [DATA_W-1:0]   w_dvdNext;
  logic [DATA_W-1:0]   w_divisorNext;
  logic                w_sign1Next;
  logic                w_sign2Next;
  logic [2*DATA_W-1:0] w_resultNext;
  logic                w_readyNext;

  logic [DATA_W-1:0] w_stepRem;
  logic [DATA_W-1:0] w_stepDvd;
  logic              w_stepQbit;
  logic              w_opSign1;
  logic              w_opSign2;
  logic [DATA_W-1:0] w_absDividend;
  logic [DATA_W-1:0] w_absDivisor;
  logic [DATA_W-1:0] w_quotFixed;
  logic [DATA_W-1:0] w_remFixed;
  logic              w_shortPath;

  div_step #(
    .DATA_W(DATA_W)
  ) u_step (
    .i_rem    (r_rem),
    .i_dvd    (r_dvd),
    .i_divisor(r_divisor),
    .o_rem    (w_stepRem),
    .o_dvd    (w_stepDvd),
    .o_qbit   (w_stepQbit)
  );

  // Operand magnitudes, sign fix-up of the final step and the short-path test.
  always_comb begin
    w_opSign1     = signed_div_i & opdata1_i[DATA_W-1];
    w_opSign2     = signed_div_i & opdata2_i[DATA_W-1];
    w_absDividend = w_opSign1 ? (~opdata1_i + 1'b1) : opdata1_i;
    w_absDivisor  = w_opSign2 ? (~opdata2_i + 1'b1) : opdata2_i;
    w_quotFixed   = (r_sign1 ^ r_sign2) ? (~w_stepDvd + 1'b1) : w_stepDvd;
    w_remFixed    = r_sign1 ? (~w_stepRem + 1'b1) : w_stepRem;
`ifdef DIV_FAST_ZERO_DIVIDEND_EN
    w_shortPath   = (opdata2_i == '0) || (opdata1_i == '0);
`else
    w_shortPath   = (opdata2_i == '0);
`endif
  end

  // Next-state and next-output logic; annul wins over stepping, END ignores it.
  always_comb begin
    w_stateNext   = r_state;
    w_cntNext     = r_cnt;
    w_remNext     = r_rem;
    w_dvdNext     = r_dvd;
    w_divisorNext = r_divisor;
    w_sign1Next   = r_sign1;
    w_sign2Next   = r_sign2;
    w_resultNext  = result_o;
    w_readyNext   = ready_o;
    unique case (r_state)
      DivFree: begin
        w_resultNext = '0;
        w_readyNext  = DivResultNotReady;
        if ((start_i == DivStart) && !annul_i) begin
          if (w_shortPath) begin
            w_stateNext = DivByZero;
          end else begin
            w_stateNext   = DivOn;
            w_cntNext     = '0;
            w_remNext     = '0;
            w_dvdNext     = w_absDividend;
            w_divisorNext = w_absDivisor;
            w_sign1Next   = w_opSign1;
            w_sign2Next   = w_opSign2;
          end
        end
      end
      DivByZero: begin
        w_resultNext = '0;
        if (annul_i) begin
          w_stateNext = DivFree;
          w_readyNext = DivResultNotReady;
        end else begin
          w_stateNext = DivEnd;
          w_readyNext = DivResultReady;
        end
      end
      DivOn: begin
        if (annul_i) begin
          w_stateNext  = DivFree;
          w_resultNext = '0;
          w_readyNext  = DivResultNotReady;
        end else begin
          w_remNext = w_stepRem;
          w_dvdNext = w_stepDvd;
          if (r_cnt == LastStep) begin
            w_stateNext  = DivEnd;
            w_resultNext = {w_remFixed, w_quotFixed};
            w_readyNext  = DivResultReady;
          end else begin
            w_cntNext = r_cnt + 1'b1;
          end
        end
      end
      DivEnd: begin
        if (start_i == DivStop) begin
          w_stateNext  = DivFree;
          w_resultNext = '0;
          w_readyNext  = DivResultNotReady;
        end
      end
      default: begin
        w_stateNext  = DivFree;
        w_resultNext = '0;
        w_readyNext  = DivResultNotReady;
      end
    endcase
  end

  // State, datapath and registered outputs; low rst clears them on the edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= DivFree;
      r_cnt     <= '0;
      r_rem     <= '0;
      r_dvd     <= '0;
      r_divisor <= '0;
      r_sign1   <= 1'b0;
      r_sign2   <= 1'b0;
      result_o  <= '0;
      ready_o   <= DivResultNotReady;
    end else begin
      r_state   <= w_stateNext;
      r_cnt     <= w_cntNext;
      r_rem     <= w_remNext;
      r_dvd     <= w_dvdNext;
      r_divisor <= w_divisorNext;
      r_sign1   <= w_sign1Next;
      r_sign2   <= w_sign2Next;
      result_o  <= w_resultNext;
      ready_o   <= w_readyNext;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: scoreboard bench for div_unit.
// Expected {remainder, quotient} and latency are pushed when a request is
// driven and popped when ready_o rises. Honours DIV_FAST_ZERO_DIVIDEND_EN.
module tb_div_unit;

  logic        clk;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  typedef struct {
    logic [63:0] result;
    int          latency;
  } expEntry_t;

  expEntry_t   sbQ[$];
  int          checkCount = 0;
  int          passCount  = 0;
  logic [63:0] lastResult;

  div_unit #(.DATA_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .signed_div_i(signed_div_i),
    .opdata1_i   (opdata1_i),
    .opdata2_i   (opdata2_i),
    .start_i     (start_i),
    .annul_i     (annul_i),
    .result_o    (result_o),
    .ready_o     (ready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference division done in 64-bit arithmetic so no corner case traps.
  function automatic logic [63:0] modelDiv(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    longint q;
    longint r;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic int modelLatency(input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return 2;
`ifdef DIV_FAST_ZERO_DIVIDEND_EN
    if (a == 32'd0) return 2;
`else
    if (a == 32'd0) return 33;
`endif
    return 33;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    annul_i      = 1'b0;
    start_i      = 1'b1;
  endtask

  task automatic pushExpected(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    expEntry_t e;
    e.result  = modelDiv(sgn, a, b);
    e.latency = modelLatency(a, b);
    sbQ.push_back(e);
  endtask

  // Counts edges until ready_o (bounded), then pops and compares.
  task automatic waitResult(input string tag, input int edgesAlready);
    int        edges;
    expEntry_t e;
    edges = edgesAlready;
    while (edges < 100) begin
      @(posedge clk);
      #1;
      edges++;
      if (ready_o) break;
    end
    checkOutput({tag, "_ready"}, 64'(ready_o), 64'd1);
    lastResult = result_o;
    if (sbQ.size() == 0) begin
      checkOutput({tag, "_sbEmpty"}, 64'd1, 64'd0);
    end else begin
      e = sbQ.pop_front();
      checkOutput({tag, "_result"}, result_o, e.result);
      checkOutput({tag, "_latency"}, 64'(edges), 64'(e.latency));
    end
  endtask

  task automatic dropStart(input string tag);
    start_i = 1'b0;
    @(posedge clk);
    #1;
    checkOutput({tag, "_dropReady"}, 64'(ready_o), 64'd0);
    checkOutput({tag, "_dropResult"}, result_o, 64'd0);
  endtask

  task automatic runDiv(input string tag, input logic sgn, input logic [31:0] a, input logic [31:0] b);
    pushExpected(sgn, a, b);
    applyStimulus(sgn, a, b);
    waitResult(tag, 0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput({tag, "_holdReady"}, 64'(ready_o), 64'd1);
    checkOutput({tag, "_holdResult"}, result_o, lastResult);
    dropStart(tag);
  endtask

  initial begin
    logic        sawReady;
    logic [31:0] ra;
    logic [31:0] rb;

    rst          = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i    = '0;
    opdata2_i    = '0;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_ready", 64'(ready_o), 64'd0);
    checkOutput("reset_result", result_o, 64'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    runDiv("divu_100_7", 1'b0, 32'd100, 32'd7);
    checkOutput("divu_100_7_const", lastResult, 64'h00000002_0000000E);
    runDiv("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
    checkOutput("div_m7_2_const", lastResult, 64'hFFFFFFFF_FFFFFFFD);
    runDiv("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE);
    checkOutput("div_7_m2_const", lastResult, 64'h00000001_FFFFFFFD);
    runDiv("divu_5_0", 1'b0, 32'd5, 32'd0);
    checkOutput("divu_5_0_const", lastResult, 64'd0);
    runDiv("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    checkOutput("div_ovf_const", lastResult, 64'h00000000_80000000);
    runDiv("divu_0_5", 1'b0, 32'd0, 32'd5);
    runDiv("divu_max", 1'b0, 32'hFFFF_FFFF, 32'd1);
    runDiv("div_m100_m7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9);

    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = (i < 3) ? ($urandom_range(1, 1000)) : $urandom;
      runDiv($sformatf("rand%0d", i), 1'(i % 2), ra, rb);
    end

    // Annul mid-division: no result, then a clean new request.
    applyStimulus(1'b0, 32'd100, 32'd7);
    repeat (10) @(posedge clk);
    #1;
    annul_i = 1'b1;
    start_i = 1'b0;
    @(posedge clk);
    #1;
    annul_i = 1'b0;
    checkOutput("annul_ready", 64'(ready_o), 64'd0);
    sawReady = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (ready_o) sawReady = 1'b1;
    end
    checkOutput("annul_noReady", 64'(sawReady), 64'd0);
    runDiv("after_annul_9_3", 1'b0, 32'd9, 32'd3);
    checkOutput("after_annul_const", lastResult, 64'd3);

    // Reset in the middle of a division, start held throughout.
    applyStimulus(1'b0, 32'd100, 32'd7);
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("midReset_ready", 64'(ready_o), 64'd0);
    checkOutput("midReset_result", result_o, 64'd0);
    rst = 1'b1;
    pushExpected(1'b0, 32'd100, 32'd7);
    waitResult("after_reset", 0);
    dropStart("after_reset");

    // Operand change while ON is ignored; start dropped mid-way still ends.
    pushExpected(1'b1, 32'hFFFF_FC18, 32'd10);
    applyStimulus(1'b1, 32'hFFFF_FC18, 32'd10);
    repeat (5) @(posedge clk);
    #1;
    opdata1_i    = 32'd7;
    opdata2_i    = 32'd0;
    signed_div_i = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    start_i = 1'b0;
    waitResult("midDrop", 10);
    @(posedge clk);
    #1;
    checkOutput("midDrop_fallReady", 64'(ready_o), 64'd0);
    checkOutput("midDrop_fallResult", result_o, 64'd0);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
